// File: rtl/vga_timing_gen_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared constants for the VGA timing generator: default 640x480@60 timing,
// the derived line/frame totals, sync polarity encodings and the widths of
// the coordinate outputs.  Imported by the interface, the divider and the top.
// Optional feature macro used elsewhere in this slice: VGA_TIMING_FRAME_CNT_EN.
// ---------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int X_W         = 11;
    localparam int Y_W         = 10;
    localparam int FRAME_CNT_W = 16;

    localparam int DEF_CLK_DIV  = 4;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;

    // Maps "sync pulse active" onto the physical pin level for a polarity.
    function automatic logic sync_level(input logic active, input logic pol);
        return active ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_if
// Video timing bundle between the timing generator (master) and the image
// generator (slave).
//   o_pixel_ce    one-clock pulse per pixel period
//   o_hsync       horizontal sync at the configured polarity
//   o_vsync       vertical sync at the configured polarity
//   o_de          high inside the active area
//   o_x / o_y     1-based active coordinates, 0 during blanking
//   o_frame_start one-clock pulse on the first pixel of a frame
//   o_frame_cnt   frame counter (only with VGA_TIMING_FRAME_CNT_EN)
// ---------------------------------------------------------------------------
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    logic           o_pixel_ce;
    logic           o_hsync;
    logic           o_vsync;
    logic           o_de;
    logic [X_W-1:0] o_x;
    logic [Y_W-1:0] o_y;
    logic           o_frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [FRAME_CNT_W-1:0] o_frame_cnt;
`endif

`ifdef VGA_TIMING_FRAME_CNT_EN
    modport master (output o_pixel_ce, o_hsync, o_vsync, o_de, o_x, o_y, o_frame_start, o_frame_cnt);
    modport slave  (input  o_pixel_ce, o_hsync, o_vsync, o_de, o_x, o_y, o_frame_start, o_frame_cnt);
`else
    modport master (output o_pixel_ce, o_hsync, o_vsync, o_de, o_x, o_y, o_frame_start);
    modport slave  (input  o_pixel_ce, o_hsync, o_vsync, o_de, o_x, o_y, o_frame_start);
`endif

endinterface

// File: rtl/vga_timing_gen_pixel_ce_gen.sv
// ---------------------------------------------------------------------------
// pixel_ce_gen
// Divides the system clock by CLK_DIV (2..16) into a pixel clock-enable.
//   i_clk     system clock
//   i_rst_n   asynchronous reset, active-low
//   i_enable  run/halt; low holds the divider at zero
//   o_ce      combinational, high for the last divider cycle of each pixel
// ---------------------------------------------------------------------------
module pixel_ce_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_enable,
    output logic o_ce
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    // Free-running modulo-CLK_DIV counter; halting restarts it from zero so
    // the first enable after a halt lands exactly CLK_DIV cycles later.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_cnt <= '0;
        end else if (!i_enable) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign o_ce = i_enable && (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// 640x480@60 (by default) VGA timing generator feeding the image generator.
//   i_clk     system clock
//   i_rst_n   asynchronous reset, active-low
//   i_enable  run/halt; low clears counters and parks all outputs
//   vid       vga_timing_gen_if.master: pixel ce, syncs, de, x/y, frame start
// Optional: define VGA_TIMING_FRAME_CNT_EN to add the 16-bit o_frame_cnt.
//
// h_cnt/v_cnt hold the position of the pixel that the next pixel-ce will
// present; on that ce the outputs register the decode of this position and
// the counters advance.  Reset therefore leaves the counters at (0,0) and the
// first ce after reset or enable presents pixel (0,0) with o_frame_start.
// ---------------------------------------------------------------------------
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   CLK_DIV  = DEF_CLK_DIV,
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic SYNC_POL = SYNC_ACTIVE_LOW
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    vga_timing_gen_if.master vid
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [X_W-1:0] H_LAST   = X_W'(H_TOTAL - 1);
    localparam logic [X_W-1:0] H_ACT    = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0] HS_START = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0] HS_END   = X_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [Y_W-1:0] V_LAST   = Y_W'(V_TOTAL - 1);
    localparam logic [Y_W-1:0] V_ACT    = Y_W'(V_ACTIVE);
    localparam logic [Y_W-1:0] VS_START = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0] VS_END   = Y_W'(V_ACTIVE + V_FP + V_SYNC);

    logic           ce;
    logic [X_W-1:0] h_cnt;
    logic [Y_W-1:0] v_cnt;
    logic           h_last, v_last, at_origin, de_now, hs_now, vs_now;

    logic           pixel_ce_q, hsync_q, vsync_q, de_q, frame_start_q;
    logic [X_W-1:0] x_q;
    logic [Y_W-1:0] y_q;

    pixel_ce_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_ce_gen (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_enable (i_enable),
        .o_ce     (ce)
    );

    // Decode of the position about to be presented.
    assign h_last    = (h_cnt == H_LAST);
    assign v_last    = (v_cnt == V_LAST);
    assign at_origin = (h_cnt == '0) && (v_cnt == '0);
    assign de_now    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs_now    = (h_cnt >= HS_START) && (h_cnt < HS_END);
    assign vs_now    = (v_cnt >= VS_START) && (v_cnt < VS_END);

    // Raster counters: horizontal wraps every line, vertical steps on each
    // horizontal wrap, so (H_LAST,V_LAST) returns both to zero on one ce.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!i_enable) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (ce) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + Y_W'(1);
            end else begin
                h_cnt <= h_cnt + X_W'(1);
            end
        end
    end

    // Output registers: pulses last one clock, the video signals are
    // reloaded on each ce and held for the rest of the pixel period.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pixel_ce_q    <= 1'b0;
            frame_start_q <= 1'b0;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
        end else if (!i_enable) begin
            pixel_ce_q    <= 1'b0;
            frame_start_q <= 1'b0;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
        end else begin
            pixel_ce_q    <= ce;
            frame_start_q <= ce && at_origin;
            if (ce) begin
                de_q    <= de_now;
                x_q     <= de_now ? h_cnt + X_W'(1) : '0;
                y_q     <= de_now ? v_cnt + Y_W'(1) : '0;
                hsync_q <= sync_level(hs_now, SYNC_POL);
                vsync_q <= sync_level(vs_now, SYNC_POL);
            end
        end
    end

    assign vid.o_pixel_ce    = pixel_ce_q;
    assign vid.o_frame_start = frame_start_q;
    assign vid.o_de          = de_q;
    assign vid.o_x           = x_q;
    assign vid.o_y           = y_q;
    assign vid.o_hsync       = hsync_q;
    assign vid.o_vsync       = vsync_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [FRAME_CNT_W-1:0] frame_cnt;

    // Counts frame starts, updating on the same edge as o_frame_start.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frame_cnt <= '0;
        end else if (!i_enable) begin
            frame_cnt <= '0;
        end else if (ce && at_origin) begin
            frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
        end
    end

    assign vid.o_frame_cnt = frame_cnt;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Directed bench for vga_timing_gen.  dut_a uses the default 640x480 timing
// for line-level behaviour; dut_b uses a tiny raster (16x13 totals, CLK_DIV 2,
// active-high syncs) so whole frames fit in a short run.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    logic clk;
    logic rst_n;
    logic en_a;
    logic en_b;

    int tests_run;
    int tests_failed;

    vga_timing_gen_if va ();
    vga_timing_gen_if vb ();

    vga_timing_gen dut_a (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_enable (en_a),
        .vid      (va)
    );

    vga_timing_gen #(
        .CLK_DIV  (2),
        .H_ACTIVE (8),
        .H_FP     (2),
        .H_SYNC   (3),
        .H_BP     (3),
        .V_ACTIVE (6),
        .V_FP     (2),
        .V_SYNC   (2),
        .V_BP     (3),
        .SYNC_POL (SYNC_ACTIVE_HIGH)
    ) dut_b (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_enable (en_b),
        .vid      (vb)
    );

    // 10 ns system clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case any wait misbehaves.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Restart dut_a from (0,0) via a one-cycle enable drop.
    task automatic restart_a();
        @(negedge clk);
        en_a = 1'b0;
        @(negedge clk);
        en_a = 1'b1;
    endtask

    task automatic restart_b();
        @(negedge clk);
        en_b = 1'b0;
        @(negedge clk);
        en_b = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en_a  = 1'b1;
        en_b  = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        tests_run++;
        if ({va.o_pixel_ce, va.o_de, va.o_frame_start, va.o_hsync, va.o_vsync} !== 5'b00011) begin
            tests_failed++;
            $display("[TB] FAIL reset_ctrl_a: got %b, expected 00011",
                     {va.o_pixel_ce, va.o_de, va.o_frame_start, va.o_hsync, va.o_vsync});
        end
        tests_run++;
        if (va.o_x !== 11'd0 || va.o_y !== 10'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_xy_a: got x=%0d y=%0d, expected 0 0", va.o_x, va.o_y);
        end
        tests_run++;
        if ({vb.o_hsync, vb.o_vsync} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL reset_sync_b: got %b, expected 00", {vb.o_hsync, vb.o_vsync});
        end
    endtask

    task automatic test_first_ce();
        logic [3:0] ce_seen;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            ce_seen[k] = va.o_pixel_ce;
        end
        tests_run++;
        if (ce_seen !== 4'b1000) begin
            tests_failed++;
            $display("[TB] FAIL first_ce_timing: got %b, expected 1000 (cycles 4..1)", ce_seen);
        end
        tests_run++;
        if (va.o_frame_start !== 1'b1 || va.o_x !== 11'd1 || va.o_y !== 10'd1 || va.o_de !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL first_pixel: got fs=%b x=%0d y=%0d de=%b, expected 1 1 1 1",
                     va.o_frame_start, va.o_x, va.o_y, va.o_de);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            ce_seen[k] = va.o_pixel_ce;
            if (k == 0) begin
                tests_run++;
                if (va.o_frame_start !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL frame_start_width: got %b, expected 0", va.o_frame_start);
                end
            end
        end
        tests_run++;
        if (ce_seen !== 4'b1000 || va.o_x !== 11'd2) begin
            tests_failed++;
            $display("[TB] FAIL ce_period: got ce=%b x=%0d, expected ce=1000 x=2", ce_seen, va.o_x);
        end
    endtask

    task automatic test_line();
        int pulses, bad, de_ce, hs_ce, hs_clk, hs_first;
        logic [10:0] exp_x;
        logic [9:0]  exp_y;
        pulses = 0; bad = 0; de_ce = 0; hs_ce = 0; hs_clk = 0; hs_first = -1;
        restart_a();
        for (int c = 0; c < 3200; c++) begin
            tick();
            if (va.o_hsync === 1'b0) hs_clk++;
            if (va.o_pixel_ce === 1'b1) begin
                exp_x = (pulses < 640) ? 11'(pulses + 1) : 11'd0;
                exp_y = (pulses < 640) ? 10'd1 : 10'd0;
                if (va.o_x !== exp_x || va.o_y !== exp_y || va.o_de !== (pulses < 640)) bad++;
                if (va.o_de === 1'b1) de_ce++;
                if (va.o_hsync === 1'b0) begin
                    hs_ce++;
                    if (hs_first < 0) hs_first = pulses;
                end
                pulses++;
            end
        end
        tests_run++;
        if (pulses != 800) begin
            tests_failed++;
            $display("[TB] FAIL line_pulses: got %0d, expected 800", pulses);
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("[TB] FAIL line_xy_de: got %0d bad pixels, expected 0", bad);
        end
        tests_run++;
        if (de_ce != 640) begin
            tests_failed++;
            $display("[TB] FAIL line_de_count: got %0d, expected 640", de_ce);
        end
        tests_run++;
        if (hs_ce != 96 || hs_clk != 384) begin
            tests_failed++;
            $display("[TB] FAIL hsync_width: got %0d ce / %0d clk, expected 96 / 384", hs_ce, hs_clk);
        end
        tests_run++;
        if (hs_first != 656) begin
            tests_failed++;
            $display("[TB] FAIL hsync_start: got %0d, expected 656", hs_first);
        end
        repeat (4) tick();
        tests_run++;
        if (va.o_pixel_ce !== 1'b1 || va.o_x !== 11'd1 || va.o_y !== 10'd2) begin
            tests_failed++;
            $display("[TB] FAIL next_line: got ce=%b x=%0d y=%0d, expected 1 1 2",
                     va.o_pixel_ce, va.o_x, va.o_y);
        end
    endtask

    task automatic test_frame();
        int first_fs, second_fs, vs_clk, vs_ce, hs_ce, de_ce, ymin, ymax;
        logic [2:0] wrap_px;
        first_fs = -1; second_fs = -1; vs_clk = 0; vs_ce = 0; hs_ce = 0; de_ce = 0;
        ymin = 1000; ymax = 0; wrap_px = 3'b000;
        restart_b();
        for (int c = 1; c <= 430; c++) begin
            tick();
            if (vb.o_frame_start === 1'b1) begin
                if (first_fs < 0) first_fs = c;
                else if (second_fs < 0) begin
                    second_fs = c;
                    wrap_px = {vb.o_de, vb.o_x == 11'd1, vb.o_y == 10'd1};
                end
            end
            if (first_fs >= 0 && second_fs < 0) begin
                if (vb.o_vsync === 1'b1) vs_clk++;
                if (vb.o_pixel_ce === 1'b1) begin
                    if (vb.o_vsync === 1'b1) vs_ce++;
                    if (vb.o_hsync === 1'b1) hs_ce++;
                    if (vb.o_de === 1'b1) begin
                        de_ce++;
                        if (int'(vb.o_y) < ymin) ymin = int'(vb.o_y);
                        if (int'(vb.o_y) > ymax) ymax = int'(vb.o_y);
                    end
                end
            end
        end
        tests_run++;
        if (first_fs != 2) begin
            tests_failed++;
            $display("[TB] FAIL frame_first_fs: got cycle %0d, expected 2", first_fs);
        end
        tests_run++;
        if (second_fs - first_fs != 416) begin
            tests_failed++;
            $display("[TB] FAIL frame_period: got %0d, expected 416", second_fs - first_fs);
        end
        tests_run++;
        if (vs_ce != 32 || vs_clk != 64) begin
            tests_failed++;
            $display("[TB] FAIL vsync_width: got %0d ce / %0d clk, expected 32 / 64", vs_ce, vs_clk);
        end
        tests_run++;
        if (hs_ce != 39) begin
            tests_failed++;
            $display("[TB] FAIL frame_hsync_count: got %0d, expected 39", hs_ce);
        end
        tests_run++;
        if (de_ce != 48 || ymin != 1 || ymax != 6) begin
            tests_failed++;
            $display("[TB] FAIL frame_de_y: got de=%0d y=%0d..%0d, expected 48 1..6", de_ce, ymin, ymax);
        end
        tests_run++;
        if (wrap_px !== 3'b111) begin
            tests_failed++;
            $display("[TB] FAIL frame_wrap_pixel: got %b, expected 111", wrap_px);
        end
    endtask

    task automatic test_enable();
        int pulses, early;
        pulses = 0; early = 0;
        restart_a();
        for (int c = 0; c < 1300 && pulses < 301; c++) begin
            tick();
            if (va.o_pixel_ce === 1'b1) pulses++;
        end
        tests_run++;
        if (va.o_x !== 11'd301 || va.o_de !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL enable_pre_x: got x=%0d de=%b, expected 301 1", va.o_x, va.o_de);
        end
        @(negedge clk);
        en_a = 1'b0;
        tick();
        tests_run++;
        if (va.o_x !== 11'd0 || va.o_de !== 1'b0 || va.o_hsync !== 1'b1 || va.o_pixel_ce !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL enable_clear: got x=%0d de=%b hs=%b ce=%b, expected 0 0 1 0",
                     va.o_x, va.o_de, va.o_hsync, va.o_pixel_ce);
        end
        for (int c = 0; c < 9; c++) begin
            tick();
            if (va.o_pixel_ce === 1'b1) early++;
        end
        @(negedge clk);
        en_a = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (va.o_pixel_ce === 1'b1) early++;
        end
        tests_run++;
        if (early != 0) begin
            tests_failed++;
            $display("[TB] FAIL enable_hold: got %0d pulses, expected 0", early);
        end
        tick();
        tests_run++;
        if (va.o_pixel_ce !== 1'b1 || va.o_frame_start !== 1'b1 || va.o_x !== 11'd1 || va.o_y !== 10'd1) begin
            tests_failed++;
            $display("[TB] FAIL enable_restart: got ce=%b fs=%b x=%0d y=%0d, expected 1 1 1 1",
                     va.o_pixel_ce, va.o_frame_start, va.o_x, va.o_y);
        end
    endtask

    task automatic test_async_reset();
        int pulses;
        logic [3:0] ce_seen;
        pulses = 0;
        restart_a();
        for (int c = 0; c < 3000 && pulses < 701; c++) begin
            tick();
            if (va.o_pixel_ce === 1'b1) pulses++;
        end
        tests_run++;
        if (va.o_hsync !== 1'b0 || pulses != 701) begin
            tests_failed++;
            $display("[TB] FAIL mid_hsync: got hs=%b pulses=%0d, expected 0 701", va.o_hsync, pulses);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (va.o_hsync !== 1'b1 || va.o_x !== 11'd0 || va.o_de !== 1'b0 || va.o_pixel_ce !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: got hs=%b x=%0d de=%b ce=%b, expected 1 0 0 0",
                     va.o_hsync, va.o_x, va.o_de, va.o_pixel_ce);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            ce_seen[k] = va.o_pixel_ce;
        end
        tests_run++;
        if (ce_seen !== 4'b1000 || va.o_frame_start !== 1'b1 || va.o_x !== 11'd1) begin
            tests_failed++;
            $display("[TB] FAIL reset_restart: got ce=%b fs=%b x=%0d, expected 1000 1 1",
                     ce_seen, va.o_frame_start, va.o_x);
        end
    endtask

`ifdef VGA_TIMING_FRAME_CNT_EN
    task automatic test_frame_cnt();
        int found;
        @(negedge clk);
        en_b = 1'b0;
        tick();
        tests_run++;
        if (vb.o_frame_cnt !== 16'd0) begin
            tests_failed++;
            $display("[TB] FAIL frame_cnt_clear: got %0d, expected 0", vb.o_frame_cnt);
        end
        restart_b();
        found = 0;
        for (int c = 0; c < 10 && found == 0; c++) begin
            tick();
            if (vb.o_frame_start === 1'b1) found = 1;
        end
        tests_run++;
        if (found != 1 || vb.o_frame_cnt !== 16'd1) begin
            tests_failed++;
            $display("[TB] FAIL frame_cnt_first: got found=%0d cnt=%0d, expected 1 1", found, vb.o_frame_cnt);
        end
        @(negedge clk);
        force dut_b.frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dut_b.frame_cnt;
        found = 0;
        for (int c = 0; c < 450 && found == 0; c++) begin
            tick();
            if (vb.o_frame_start === 1'b1) found = 1;
        end
        tests_run++;
        if (found != 1 || vb.o_frame_cnt !== 16'd0) begin
            tests_failed++;
            $display("[TB] FAIL frame_cnt_wrap: got found=%0d cnt=%0d, expected 1 0", found, vb.o_frame_cnt);
        end
    endtask
`endif

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        en_a  = 1'b0;
        en_b  = 1'b0;
        test_reset();
        test_first_ce();
        test_line();
        test_frame();
        test_enable();
        test_async_reset();
`ifdef VGA_TIMING_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
